alu_shift_seq: RTL
==================

Name: alu_shift_seq

Overview:
- Multi-cycle sequencer for the ALU shift/rotate path: ROL, ROR, SHL, SHR, SHRA.
- Accepts one operation per start pulse and applies the shift amount in log2 stages, one stage per clock (amounts 1, 2, 4, 8, 16).
- Latency is fixed, so the top-level control unit can time its register-file load deterministically.
- Sits between the control unit and the Z/result register of the datapath.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two, at least 2.
- CNT_WIDTH, 5, shift-count width; equals log2(DATA_WIDTH). Also the number of stages, so latency is CNT_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  operation code (encodings in package).
- data_input  input  DATA_WIDTH  operand.
- num_shifts  input  CNT_WIDTH  shift/rotate amount, 0..DATA_WIDTH-1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: data_output is valid.
- data_output  output  DATA_WIDTH  result; holds its value until the next completion.

Behaviour:
- The single clock is clk. Reset clr_n is asynchronous and active-low. While clr_n=0 these hold:
  - state=IDLE, stage=0.
  - busy=0, done=0, data_output=0.
  - internal work/op/count registers are 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1. Stage counter k runs from 0 to CNT_WIDTH-1.
- Accept: at the rising edge ending cycle T, if state=IDLE and start=1:
  - latch data_input into the work register, and latch op and num_shifts;
  - set k=0 and go to RUN.
- Stepping: each edge in RUN applies stage k to the work register.
  - If num_shifts[k]=1, shift or rotate by 2^k per the latched op. Otherwise the value passes unchanged.
  - Then k increments.
- Completion: on the edge where k=CNT_WIDTH-1 is applied:
  - data_output takes the final work value and done is registered high;
  - state returns to IDLE and busy drops.
- Timing: busy is high in cycles T+1..T+CNT_WIDTH. done is high in cycle T+CNT_WIDTH+1 only. Total latency is CNT_WIDTH+1 edges from accept to done visible.
- Latency is fixed regardless of count. num_shifts=0 gives data_output=data_input after the same latency.
- Op semantics (applied per stage, amount a=2^k):
  - ROL: bits leaving the MSB re-enter at the LSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - SHL: zeros fill from the LSB.
  - SHR: zeros fill from the MSB.
  - SHRA: the current MSB replicates into the vacated MSBs.
  - Composition over stages equals a single shift by num_shifts.
- Illegal op codes (101, 110, 111) behave as pass-through. The full latency and done pulse still occur.
- start while busy=1 is ignored. It is not queued and does not alter the latched operands.
- Inputs may change after the accept cycle without affecting the result.
- Back-to-back: the done cycle is an IDLE cycle, so start there is accepted. The new busy rises on the next edge while done falls.
- Asynchronous clr_n assertion mid-RUN aborts the operation immediately, with no done pulse. data_output is cleared to 0.
- There are no combinational paths from inputs to outputs. All outputs are registered.

Decomposition:
- Package alu_shift_pkg holds:
  - op encodings ROL=3'b000, ROR=3'b001, SHL=3'b010, SHR=3'b011, SHRA=3'b100;
  - a state enum {IDLE, RUN};
  - the DATA_WIDTH/CNT_WIDTH defaults.
- Sub-module alu_shift_stage is combinational. Its inputs are the value, op, stage index k and enable bit. Its output is the value after one conditional 2^k shift/rotate.
- The top level is instantiated with the stage selected by counter k. There is one stage instance, muxed per cycle, not CNT_WIDTH instances.

Test Plan:
- ROL: data_input=0x80000001, num_shifts=1, start at cycle 0 -> busy high cycles 1-5, done pulse cycle 6, data_output=0x00000003.
- ROR: data_input=0x00000001, num_shifts=4 -> data_output=0x10000000. Also ROL 0x12345678 by 16 -> 0x56781234.
- Shifts of 0x80000000 by 31:
  - SHRA -> 0xFFFFFFFF.
  - SHR -> 0x00000001.
  - SHL of 0xFFFFFFFF by 31 -> 0x80000000.
- Zero count and illegal op:
  - num_shifts=0 with op=ROL, data_input=0xDEADBEEF -> 0xDEADBEEF, done at cycle 6.
  - op=3'b111 -> pass-through, done at cycle 6.
- Start handling:
  - start held high cycles 0-3 with a different operand at cycle 2 -> only the first operation is performed.
  - start asserted in the done cycle -> second operation accepted, its done arrives 6 cycles later.
- Reset mid-operation: clr_n low during cycle 3 of an operation -> busy=0, done=0, data_output=0 immediately, and no done pulse. After release, a new ROR 0x0000000F by 4 -> 0xF0000000.

Source files
------------

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate sequencer:
// op encodings, control states and default widths.
package alu_shift_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 5;

  localparam logic [2:0] OP_ROL  = 3'b000;
  localparam logic [2:0] OP_ROR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_SHRA = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_shift_stage.sv
// One conditional shift/rotate by 2^k; the top reuses this single
// stage every cycle with k supplied by its stage counter.
module alu_shift_stage
  import alu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int KW         = 3
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [2:0]            op,
  input  logic [KW-1:0]         k,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] result
);

  logic [CNT_WIDTH-1:0]  amt;
  logic [CNT_WIDTH-1:0]  inv;
  logic [DATA_WIDTH-1:0] rol;
  logic [DATA_WIDTH-1:0] ror;
  logic [DATA_WIDTH-1:0] sra;

  // amt never exceeds DATA_WIDTH/2, so the modular negate is DATA_WIDTH-amt
  assign amt = CNT_WIDTH'(1) << k;
  assign inv = ~amt + CNT_WIDTH'(1);
  assign rol = (value << amt) | (value >> inv);
  assign ror = (value >> amt) | (value << inv);
  assign sra = $signed(value) >>> amt;

  always_comb begin
    result = value;
    if (en) begin
      case (op)
        OP_ROL:  result = rol;
        OP_ROR:  result = ror;
        OP_SHL:  result = value << amt;
        OP_SHR:  result = value >> amt;
        OP_SHRA: result = sra;
        default: result = value;
      endcase
    end
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Fixed-latency shift/rotate sequencer: one log2 stage per clock,
// CNT_WIDTH stages, done pulse one cycle after the last stage.
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic [CNT_WIDTH-1:0]  num_shifts,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_output
);

  localparam int KW = (CNT_WIDTH > 1) ? $clog2(CNT_WIDTH) : 1;
  localparam logic [KW-1:0] LAST = KW'(CNT_WIDTH - 1);

  state_e                state;
  logic [KW-1:0]         k;
  logic [DATA_WIDTH-1:0] work;
  logic [2:0]            op_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] step;

  alu_shift_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .KW         (KW)
  ) u_stage (
    .value  (work),
    .op     (op_q),
    .k      (k),
    .en     (cnt_q[k]),
    .result (step)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      k           <= '0;
      work        <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      data_output <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= data_input;
            op_q  <= op;
            cnt_q <= num_shifts;
            k     <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          work <= step;
          k    <= k + KW'(1);
          if (k == LAST) begin
            data_output <= step;
            done        <= 1'b1;
            busy        <= 1'b0;
            k           <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
